// File: rtl/tx_pattern_gen.sv
// Serial TX pattern source (PRBS7..31, clock, user pattern, zeros) feeding the FFE data input.
// Optional output error injection with saturating counter: define TX_ERR_INJ_EN.
module tx_pattern_gen #(
    parameter int USER_PAT_WIDTH = 16,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [2:0]                mode,
    input  logic [30:0]               seed,
    input  logic [USER_PAT_WIDTH-1:0] user_pat,
    input  logic                      inj,
    output logic                      out,
    output logic                      valid,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

    localparam int IDX_W = (USER_PAT_WIDTH > 1) ? $clog2(USER_PAT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(USER_PAT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;

    state_t                    state, state_nx;
    logic [30:0]               lfsr, lfsr_nx, seed_ld;
    logic [2:0]                mode_r;
    logic [USER_PAT_WIDTH-1:0] upat_r;
    logic [IDX_W-1:0]          idx, idx_rev;
    logic                      bit_sel, inj_hit;
    logic [4:0]                ord_r, tap_r, ord_in;

    function automatic logic [4:0] prbs_order(input logic [2:0] m);
        case (m)
            3'd1:    prbs_order = 5'd9;
            3'd2:    prbs_order = 5'd15;
            3'd3:    prbs_order = 5'd23;
            3'd4:    prbs_order = 5'd31;
            default: prbs_order = 5'd7;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [2:0] m);
        case (m)
            3'd1:    prbs_tap = 5'd5;
            3'd2:    prbs_tap = 5'd14;
            3'd3:    prbs_tap = 5'd18;
            3'd4:    prbs_tap = 5'd28;
            default: prbs_tap = 5'd6;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // load restarts from any state and wins over en
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = LOAD;
            LOAD:    if (load) state_nx = LOAD;
                     else      state_nx = en ? RUN : PAUSE;
            RUN:     if (load) state_nx = LOAD;
                     else if (!en) state_nx = PAUSE;
            PAUSE:   if (load) state_nx = LOAD;
                     else if (en) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ord_r   = prbs_order(mode_r);
        tap_r   = prbs_tap(mode_r);
        ord_in  = prbs_order(mode);
        lfsr_nx = ({lfsr[29:0], lfsr[ord_r - 5'd1] ^ lfsr[tap_r - 5'd1]})
                  & (31'h7FFF_FFFF >> (5'd31 - ord_r));
        seed_ld = seed & (31'h7FFF_FFFF >> (5'd31 - ord_in));
        if (mode <= 3'd4 && seed_ld == 31'd0)
            seed_ld = 31'h7FFF_FFFF >> (5'd31 - ord_in);
        idx_rev = IDX_LAST - idx;
        case (mode_r)
            3'd5:    bit_sel = ~idx[0];
            3'd6:    bit_sel = upat_r[idx_rev];
            3'd7:    bit_sel = 1'b0;
            default: bit_sel = lfsr[ord_r - 5'd1];
        endcase
    end

`ifdef TX_ERR_INJ_EN
    // only a request that produces an emitted bit is honoured and counted
    assign inj_hit = inj && (state == RUN) && (state_nx == RUN);

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (inj_hit && err_cnt != {ERR_CNT_WIDTH{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
`else
    logic unused_inj;
    assign unused_inj = inj;
    assign inj_hit    = 1'b0;
    assign err_cnt    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= 1'b0;
            valid  <= 1'b0;
            lfsr   <= 31'h7FFF_FFFF;
            mode_r <= 3'd0;
            upat_r <= '0;
            idx    <= '0;
        end else if (state_nx == LOAD) begin
            out    <= 1'b0;
            valid  <= 1'b0;
            mode_r <= mode;
            upat_r <= user_pat;
            lfsr   <= seed_ld;
            idx    <= '0;
        end else if (state_nx == RUN) begin
            out   <= bit_sel ^ inj_hit;
            valid <= 1'b1;
            if (mode_r <= 3'd4)
                lfsr <= lfsr_nx;
            else if (mode_r == 3'd5)
                idx <= idx ^ IDX_W'(1);
            else if (mode_r == 3'd6)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            out   <= 1'b0;
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Self-checking bench for tx_pattern_gen; PRBS reference built from the x[n]=x[n-W]^x[n-T] recurrence.
// Error-injection scenarios are exercised when TX_ERR_INJ_EN is defined.
module tb_tx_pattern_gen;

    logic        clk = 1'b0;
    logic        rst, en, load, inj;
    logic [2:0]  mode;
    logic [30:0] seed;
    logic [15:0] user_pat;
    logic        out, valid;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;
    bit ref_bits [0:1199];
    bit got_bits [0:1199];

    tx_pattern_gen #(.USER_PAT_WIDTH(16), .ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode), .seed(seed),
        .user_pat(user_pat), .inj(inj), .out(out), .valid(valid), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_prbs(input int m, input logic [30:0] s);
        int w, t;
        logic [30:0] sv;
        case (m)
            1: begin w = 9;  t = 5;  end
            2: begin w = 15; t = 14; end
            3: begin w = 23; t = 18; end
            4: begin w = 31; t = 28; end
            default: begin w = 7; t = 6; end
        endcase
        sv = s & ((31'h7FFF_FFFF) >> (31 - w));
        if (sv == 0) sv = (31'h7FFF_FFFF) >> (31 - w);
        for (int i = 0; i < w; i++) ref_bits[i] = sv[w-1-i];
        for (int i = w; i < 1200; i++) ref_bits[i] = ref_bits[i-w] ^ ref_bits[i-t];
    endtask

    // Pulses load, scrambles the config inputs afterwards; returns with bit 0 on out.
    task automatic do_load(input logic [2:0] m, input logic [30:0] s, input logic [15:0] u);
        mode = m; seed = s; user_pat = u; load = 1'b1;
        tick();
        load = 1'b0;
        mode = 3'($urandom); seed = 31'($urandom); user_pat = 16'($urandom);
        total++;
        if (valid !== 1'b0 || out !== 1'b0) begin
            bad++;
            $display("FAIL load_cycle: out=%b valid=%b want out=0 valid=0", out, valid);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; inj = 1'b0;
        mode = 3'd0; seed = '0; user_pat = '0;
        tick(); tick();
        total++;
        if (out !== 1'b0 || valid !== 1'b0 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset: out=%b valid=%b err_cnt=%h want 0 0 0000", out, valid, err_cnt);
        end
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_load: valid=%b want 0", valid);
        end
    endtask

    task automatic test_prbs7();
        int ones;
        bit per_ok;
        build_prbs(0, 31'h7F);
        en = 1'b1;
        do_load(3'd0, 31'h7F, 16'h0);
        for (int i = 0; i < 254; i++) begin
            got_bits[i] = out;
            total++;
            if (valid !== 1'b1 || out !== ref_bits[i]) begin
                bad++;
                $display("FAIL prbs7 bit %0d: out=%b valid=%b want out=%b valid=1", i, out, valid, ref_bits[i]);
            end
            tick();
        end
        ones = 0;
        per_ok = 1'b1;
        for (int i = 0; i < 127; i++) begin
            ones += int'(got_bits[i]);
            if (got_bits[i] != got_bits[i+127]) per_ok = 1'b0;
        end
        total++;
        if (ones != 64) begin
            bad++;
            $display("FAIL prbs7 ones: got %0d want 64", ones);
        end
        total++;
        if (!per_ok) begin
            bad++;
            $display("FAIL prbs7 period: got non-repeating want period 127");
        end
        total++;
        if (got_bits[0:6] != '{7{1'b1}} || got_bits[7] != 1'b0) begin
            bad++;
            $display("FAIL prbs7 head: got %b%b%b%b%b%b%b%b want 11111110", got_bits[0], got_bits[1],
                     got_bits[2], got_bits[3], got_bits[4], got_bits[5], got_bits[6], got_bits[7]);
        end
    endtask

    task automatic test_prbs31_zero_seed();
        build_prbs(4, 31'h0);
        en = 1'b1;
        do_load(3'd4, 31'h0, 16'h0);
        for (int i = 0; i < 1000; i++) begin
            total++;
            if (valid !== 1'b1 || out !== ref_bits[i]) begin
                bad++;
                $display("FAIL prbs31 bit %0d: out=%b valid=%b want out=%b valid=1", i, out, valid, ref_bits[i]);
            end
            tick();
        end
    endtask

    task automatic test_prbs_random();
        int m;
        logic [30:0] s;
        en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            m = int'($urandom_range(0, 4));
            s = (r == 2) ? 31'h0 : 31'($urandom);
            build_prbs(m, s);
            do_load(3'(m), s, 16'h0);
            for (int i = 0; i < 200; i++) begin
                total++;
                if (valid !== 1'b1 || out !== ref_bits[i]) begin
                    bad++;
                    $display("FAIL prbs_rand m=%0d seed=%h bit %0d: out=%b want %b", m, s, i, out, ref_bits[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_user_pattern();
        logic [15:0] pat, pat2;
        pat = 16'hA5C3;
        en = 1'b1;
        do_load(3'd6, 31'h0, pat);
        for (int i = 0; i < 48; i++) begin
            total++;
            if (valid !== 1'b1 || out !== pat[15 - (i % 16)]) begin
                bad++;
                $display("FAIL user bit %0d: out=%b want %b", i, out, pat[15 - (i % 16)]);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) tick();
        pat2 = 16'($urandom);
        do_load(3'd6, 31'h0, pat2);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (valid !== 1'b1 || out !== pat2[15 - (i % 16)]) begin
                bad++;
                $display("FAIL user_reload bit %0d: out=%b want %b", i, out, pat2[15 - (i % 16)]);
            end
            tick();
        end
    endtask

    task automatic test_clock_and_zero();
        en = 1'b1;
        do_load(3'd5, 31'h0, 16'h0);
        for (int i = 0; i < 21; i++) begin
            total++;
            if (valid !== 1'b1 || out !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL clock bit %0d: out=%b want %b", i, out, ((i % 2) == 0));
            end
            tick();
        end
        do_load(3'd7, 31'h5, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (valid !== 1'b1 || out !== 1'b0) begin
                bad++;
                $display("FAIL zero bit %0d: out=%b valid=%b want out=0 valid=1", i, out, valid);
            end
            tick();
        end
    endtask

    task automatic test_pause();
        logic [30:0] s;
        s = 31'($urandom);
        build_prbs(1, s);
        en = 1'b1;
        do_load(3'd1, s, 16'h0);
        for (int i = 0; i <= 40; i++) begin
            total++;
            if (valid !== 1'b1 || out !== ref_bits[i]) begin
                bad++;
                $display("FAIL pause_pre bit %0d: out=%b want %b", i, out, ref_bits[i]);
            end
            if (i < 40) tick();
        end
        en = 1'b0;
        for (int p = 0; p < 5; p++) begin
            tick();
            total++;
            if (valid !== 1'b0 || out !== 1'b0) begin
                bad++;
                $display("FAIL pause cycle %0d: out=%b valid=%b want 0 0", p, out, valid);
            end
        end
        en = 1'b1;
        tick();
        for (int i = 41; i < 100; i++) begin
            total++;
            if (valid !== 1'b1 || out !== ref_bits[i]) begin
                bad++;
                $display("FAIL pause_resume bit %0d: out=%b want %b", i, out, ref_bits[i]);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid_run();
        int seen;
        en = 1'b1;
        do_load(3'd5, 31'h0, 16'h0);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: out=%b valid=%b want 0 0", out, valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid !== 1'b0 || out !== 1'b0) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_idle: active cycles=%0d want 0", seen);
        end
    endtask

`ifdef TX_ERR_INJ_EN
    task automatic test_err_inject();
        en = 1'b1;
        do_load(3'd5, 31'h0, 16'h0);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (valid !== 1'b1 || out !== (((i % 2) == 0) ^ (i == 3 || i == 8))) begin
                bad++;
                $display("FAIL inj bit %0d: out=%b want %b", i, out, (((i % 2) == 0) ^ (i == 3 || i == 8)));
            end
            inj = (i + 1 == 3) || (i + 1 == 8);
            tick();
        end
        inj = 1'b0;
        total++;
        if (err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL inj_count: err_cnt=%0d want 2", err_cnt);
        end
        en = 1'b0;
        tick();
        inj = 1'b1;
        tick(); tick(); tick();
        inj = 1'b0;
        total++;
        if (err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL inj_pause: err_cnt=%0d want 2", err_cnt);
        end
        en = 1'b1;
        do_load(3'd7, 31'h0, 16'h0);
        total++;
        if (err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL inj_load_keep: err_cnt=%0d want 2", err_cnt);
        end
        inj = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        total++;
        if (err_cnt !== 16'hFFFF || out !== 1'b1 || valid !== 1'b1) begin
            bad++;
            $display("FAIL inj_sat: err_cnt=%h out=%b want FFFF out=1", err_cnt, out);
        end
        inj = 1'b0;
        tick();
        total++;
        if (err_cnt !== 16'hFFFF || out !== 1'b0) begin
            bad++;
            $display("FAIL inj_sat_hold: err_cnt=%h out=%b want FFFF out=0", err_cnt, out);
        end
    endtask
`else
    task automatic test_err_inject();
        en = 1'b1;
        do_load(3'd5, 31'h0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (valid !== 1'b1 || out !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL inj_ignored bit %0d: out=%b want %b", i, out, ((i % 2) == 0));
            end
            inj = 1'($urandom);
            tick();
        end
        inj = 1'b0;
        total++;
        if (err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL inj_ignored_cnt: err_cnt=%0d want 0", err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_prbs7();
        test_prbs31_zero_seed();
        test_prbs_random();
        test_user_pattern();
        test_clock_and_zero();
        test_pause();
        test_rst_mid_run();
        test_err_inject();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
